// File: rtl/riscv_dcache_wb_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped write-back data cache.
// The slave modport is the cache; the master modport is the environment that drives it
// (the MEM-stage requester plus the backing data memory).
interface riscv_dcache_wb_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_be;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready;
  logic              cpu_busy;
  logic              flush;
  logic              flush_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, flush, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_busy, flush_done, mem_req, mem_we, mem_addr,
           mem_wdata, hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, flush, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_busy, flush_done, mem_req, mem_we, mem_addr,
           mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/riscv_dcache_wb.sv
// Direct-mapped, write-back / write-allocate data cache with one 32-bit word per line.
// Misses evict a dirty victim first, then refill; stores merge byte lanes on top of the
// line. A flush walks every index and writes back dirty lines. Hit/miss counters saturate.
module riscv_dcache_wb #(
  parameter int ADDR_W = 32,
  parameter int LINES  = 4,
  parameter int CNT_W  = 16
) (
  input logic               clock,
  input logic               reset,
  riscv_dcache_wb_if.slave  bus
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINES - 1);

  typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB} state_t;

  state_t            state_reg;
  logic [LINES-1:0]  valid_reg;
  logic [LINES-1:0]  dirty_reg;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  // Miss context captured in IDLE, replayed when the refill returns.
  logic [ADDR_W-3:0] lat_word_reg;
  logic              lat_we_reg;
  logic [31:0]       lat_wdata_reg;
  logic [3:0]        lat_be_reg;
  logic [IDX_W-1:0]  scan_idx_reg;

  logic [31:0]       cpu_rdata_reg;
  logic              cpu_ready_reg;
  logic              flush_done_reg;
  logic              mem_req_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [31:0]       mem_wdata_reg;
  logic [CNT_W-1:0]  hit_count_reg;
  logic [CNT_W-1:0]  miss_count_reg;

  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [IDX_W-1:0]  lat_idx;
  logic [TAG_W-1:0]  lat_tag;
  logic              line_hit;
  logic              mem_done;
  logic [31:0]       store_merged;
  logic [31:0]       refill_merged;
  logic [31:0]       refill_word;
  logic              unused_addr_bits;

  assign cpu_idx  = bus.cpu_addr[IDX_W+1:2];
  assign cpu_tag  = bus.cpu_addr[ADDR_W-1:IDX_W+2];
  assign lat_idx  = lat_word_reg[IDX_W-1:0];
  assign lat_tag  = lat_word_reg[ADDR_W-3:IDX_W];
  assign line_hit = valid_reg[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  // An ack only counts while a request is actually outstanding.
  assign mem_done = bus.mem_ack && mem_req_reg;
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  // Byte-lane merge: store data over the cached word (hit) or over the refill data (miss).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign store_merged[8*gi +: 8]  = bus.cpu_be[gi] ? bus.cpu_wdata[8*gi +: 8]
                                                     : data_mem[cpu_idx][8*gi +: 8];
    assign refill_merged[8*gi +: 8] = lat_be_reg[gi] ? lat_wdata_reg[8*gi +: 8]
                                                     : bus.mem_rdata[8*gi +: 8];
  end
  assign refill_word = lat_we_reg ? refill_merged : bus.mem_rdata;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [TAG_W-1:0]  wr_tag;
  logic [31:0]       wr_data;

  // Select the single tag/data write per cycle: a store hit or a completed refill.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = cpu_idx;
    wr_tag  = cpu_tag;
    wr_data = store_merged;
    if (state_reg == IDLE && !bus.flush && bus.cpu_req && line_hit && bus.cpu_we) begin
      wr_en = 1'b1;
    end else if (state_reg == REFILL && mem_done) begin
      wr_en   = 1'b1;
      wr_idx  = lat_idx;
      wr_tag  = lat_tag;
      wr_data = refill_word;
    end
  end

  // Tag/data storage; contents are meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  // Controller FSM with registered CPU/memory outputs, line state and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      valid_reg      <= '0;
      dirty_reg      <= '0;
      lat_word_reg   <= '0;
      lat_we_reg     <= 1'b0;
      lat_wdata_reg  <= '0;
      lat_be_reg     <= '0;
      scan_idx_reg   <= '0;
      cpu_rdata_reg  <= '0;
      cpu_ready_reg  <= 1'b0;
      flush_done_reg <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      cpu_ready_reg  <= 1'b0;
      flush_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.flush) begin
            // Flush wins; a same-cycle CPU request is dropped and must be retried.
            state_reg    <= FLUSH_SCAN;
            scan_idx_reg <= '0;
          end else if (bus.cpu_req) begin
            if (line_hit) begin
              cpu_ready_reg <= 1'b1;
              cpu_rdata_reg <= bus.cpu_we ? store_merged : data_mem[cpu_idx];
              if (bus.cpu_we && (bus.cpu_be != 4'b0000)) dirty_reg[cpu_idx] <= 1'b1;
              if (hit_count_reg != {CNT_W{1'b1}}) hit_count_reg <= hit_count_reg + CNT_W'(1);
            end else begin
              if (miss_count_reg != {CNT_W{1'b1}}) miss_count_reg <= miss_count_reg + CNT_W'(1);
              lat_word_reg  <= bus.cpu_addr[ADDR_W-1:2];
              lat_we_reg    <= bus.cpu_we;
              lat_wdata_reg <= bus.cpu_wdata;
              lat_be_reg    <= bus.cpu_be;
              mem_req_reg   <= 1'b1;
              if (valid_reg[cpu_idx] && dirty_reg[cpu_idx]) begin
                state_reg     <= WRITEBACK;
                mem_we_reg    <= 1'b1;
                mem_addr_reg  <= {tag_mem[cpu_idx], cpu_idx, 2'b00};
                mem_wdata_reg <= data_mem[cpu_idx];
              end else begin
                state_reg    <= REFILL;
                mem_we_reg   <= 1'b0;
                mem_addr_reg <= {bus.cpu_addr[ADDR_W-1:2], 2'b00};
              end
            end
          end
        end
        WRITEBACK: begin
          // mem_req stays high straight into the refill.
          if (mem_done) begin
            state_reg    <= REFILL;
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= {lat_word_reg, 2'b00};
          end
        end
        REFILL: begin
          if (mem_done) begin
            state_reg          <= IDLE;
            mem_req_reg        <= 1'b0;
            valid_reg[lat_idx] <= 1'b1;
            dirty_reg[lat_idx] <= lat_we_reg && (lat_be_reg != 4'b0000);
            cpu_ready_reg      <= 1'b1;
            cpu_rdata_reg      <= refill_word;
          end
        end
        FLUSH_SCAN: begin
          if (dirty_reg[scan_idx_reg]) begin
            state_reg     <= FLUSH_WB;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b1;
            mem_addr_reg  <= {tag_mem[scan_idx_reg], scan_idx_reg, 2'b00};
            mem_wdata_reg <= data_mem[scan_idx_reg];
          end else if (scan_idx_reg == LAST_IDX) begin
            state_reg      <= IDLE;
            flush_done_reg <= 1'b1;
          end else begin
            scan_idx_reg <= scan_idx_reg + IDX_W'(1);
          end
        end
        FLUSH_WB: begin
          if (mem_done) begin
            mem_req_reg             <= 1'b0;
            dirty_reg[scan_idx_reg] <= 1'b0;
            if (scan_idx_reg == LAST_IDX) begin
              state_reg      <= IDLE;
              flush_done_reg <= 1'b1;
            end else begin
              state_reg    <= FLUSH_SCAN;
              scan_idx_reg <= scan_idx_reg + IDX_W'(1);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata  = cpu_rdata_reg;
  assign bus.cpu_ready  = cpu_ready_reg;
  assign bus.cpu_busy   = (state_reg != IDLE);
  assign bus.flush_done = flush_done_reg;
  assign bus.mem_req    = mem_req_reg;
  assign bus.mem_we     = mem_we_reg;
  assign bus.mem_addr   = mem_addr_reg;
  assign bus.mem_wdata  = mem_wdata_reg;
  assign bus.hit_count  = hit_count_reg;
  assign bus.miss_count = miss_count_reg;
endmodule

// File: tb/tb_riscv_dcache_wb.sv
// Bench for riscv_dcache_wb: directed scenarios plus randomized traffic, checked against
// an architectural model (CPU-visible memory image + per-index valid/tag/dirty) and a
// backing-memory responder that compares every memory request with the model's queue.
module tb_riscv_dcache_wb;
  localparam int ADDR_W = 32;
  localparam int LINES  = 4;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;

  riscv_dcache_wb_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  riscv_dcache_wb #(.ADDR_W(ADDR_W), .LINES(LINES), .CNT_W(CNT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory images ----------------
  logic [31:0] mem_words [logic [31:0]];   // backing memory as seen by the responder
  logic [31:0] arch_mem  [logic [31:0]];   // what the CPU must observe

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_words.exists(a)) return mem_words[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    if (arch_mem.exists(a)) return arch_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  // ---------------- behavioural cache model ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_op_t;

  mem_op_t     exp_q[$];
  bit          m_valid [LINES];
  bit          m_dirty [LINES];
  logic [31:0] m_tag   [LINES];
  int          m_hits;
  int          m_misses;

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    m_hits   = 0;
    m_misses = 0;
    arch_mem = mem_words;   // dirty data that never reached memory is lost
  endtask

  task automatic model_op(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [3:0] be, output bit hit, output logic [31:0] rdata,
                          output int n_ops);
    logic [31:0] wa;
    logic [31:0] tag;
    logic [31:0] va;
    int          idx;
    mem_op_t     op;
    wa    = addr & ~32'd3;
    idx   = int'((addr >> 2) % LINES);
    tag   = addr >> (IDX_W + 2);
    n_ops = 0;
    hit   = m_valid[idx] && (m_tag[idx] == tag);
    if (hit) begin
      if (m_hits < CMAX) m_hits++;
    end else begin
      if (m_misses < CMAX) m_misses++;
      if (m_valid[idx] && m_dirty[idx]) begin
        va       = (m_tag[idx] << (IDX_W + 2)) | (32'(idx) << 2);
        op.we    = 1'b1;
        op.addr  = va;
        op.wdata = arch_rd(va);
        exp_q.push_back(op);
        n_ops++;
      end
      op.we    = 1'b0;
      op.addr  = wa;
      op.wdata = '0;
      exp_q.push_back(op);
      n_ops++;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (we) begin
      arch_mem[wa] = merge(arch_rd(wa), wdata, be);
      if (be != 4'b0000) m_dirty[idx] = 1'b1;
    end
    rdata = arch_rd(wa);
  endtask

  task automatic model_flush(output int n_ops);
    mem_op_t     op;
    logic [31:0] va;
    n_ops = 0;
    for (int i = 0; i < LINES; i++) begin
      if (m_dirty[i]) begin
        va       = (m_tag[i] << (IDX_W + 2)) | (32'(i) << 2);
        op.we    = 1'b1;
        op.addr  = va;
        op.wdata = arch_rd(va);
        exp_q.push_back(op);
        n_ops++;
        m_dirty[i] = 1'b0;
      end
    end
  endtask

  // ---------------- memory responder / compare process ----------------
  int fixed_delay = 3;   // <0 selects a random ack delay
  int mem_acks    = 0;

  initial begin
    mem_op_t cur;
    mem_op_t e;
    bit      serving;
    int      cnt;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    serving       = 1'b0;
    cnt           = 0;
    cur.we = 1'b0; cur.addr = '0; cur.wdata = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        bus.mem_ack = 1'b0;
        serving     = 1'b0;
        continue;
      end
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        serving     = 1'b0;
      end
      if (!serving) begin
        if (bus.mem_req) begin
          check("mem_addr_align", 32'(bus.mem_addr[1:0]), 32'd0);
          cur.we    = bus.mem_we;
          cur.addr  = bus.mem_addr;
          cur.wdata = bus.mem_wdata;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL mem_unexpected: got we=%0b addr=0x%08h, expected no request (t=%0t)",
                     cur.we, cur.addr, $time);
          end else begin
            e = exp_q.pop_front();
            check("mem_we", 32'(cur.we), 32'(e.we));
            check("mem_addr", cur.addr, e.addr);
            if (e.we) check("mem_wdata", cur.wdata, e.wdata);
          end
          serving = 1'b1;
          cnt     = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        end
      end else begin
        check("mem_req_hold", 32'(bus.mem_req), 32'd1);
        check("mem_addr_hold", bus.mem_addr, cur.addr);
      end
      if (serving && !bus.mem_ack) begin
        if (cnt == 0) begin
          bus.mem_ack = 1'b1;
          if (cur.we) mem_words[cur.addr] = cur.wdata;
          else        bus.mem_rdata = mem_rd(cur.addr);
          mem_acks++;
        end else begin
          cnt--;
        end
      end
    end
  end

  // ---------------- CPU-side transactions ----------------
  task automatic preset(input logic [31:0] a, input logic [31:0] v);
    mem_words[a] = v;
    arch_mem[a]  = v;
  endtask

  task automatic cpu_op(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] got);
    bit          hit;
    logic [31:0] exp_rd;
    int          n_ops;
    int          acks0;
    int          cyc;
    model_op(addr, we, wdata, be, hit, exp_rd, n_ops);
    acks0         = mem_acks;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_be    = be;
    @(negedge clock);
    bus.cpu_req = 1'b0;
    cyc = 1;
    while (!bus.cpu_ready && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("cpu_ready", 32'(bus.cpu_ready), 32'd1);
    if (hit) check("hit_latency", 32'(cyc), 32'd1);
    check("cpu_rdata", bus.cpu_rdata, exp_rd);
    check("mem_ops_before_ready", 32'(mem_acks - acks0), 32'(n_ops));
    check("hit_count", 32'(bus.hit_count), 32'(m_hits));
    check("miss_count", 32'(bus.miss_count), 32'(m_misses));
    got = bus.cpu_rdata;
    $display("%s addr=0x%08h be=%b %s rdata=0x%08h mem_ops=%0d cyc=%0d",
             we ? "ST" : "LD", addr, be, hit ? "hit " : "miss", got, n_ops, cyc);
  endtask

  task automatic do_flush(input bit with_req, input logic [31:0] req_addr);
    int n_ops;
    int acks0;
    int cyc;
    bit rdy;
    model_flush(n_ops);
    acks0     = mem_acks;
    bus.flush = 1'b1;
    if (with_req) begin
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = req_addr;
      bus.cpu_be   = 4'b0000;
    end
    @(negedge clock);
    bus.flush   = 1'b0;
    bus.cpu_req = 1'b0;
    cyc = 1;
    rdy = 1'b0;
    while (!bus.flush_done && cyc < 200) begin
      if (bus.cpu_ready) rdy = 1'b1;
      @(negedge clock);
      cyc++;
    end
    if (bus.cpu_ready) rdy = 1'b1;
    check("flush_done", 32'(bus.flush_done), 32'd1);
    check("flush_no_ready", 32'(rdy), 32'd0);
    check("flush_mem_ops", 32'(mem_acks - acks0), 32'(n_ops));
    if (n_ops == 0) check("flush_clean_cycles", 32'(cyc), 32'(LINES + 1));
    check("flush_hit_count", 32'(bus.hit_count), 32'(m_hits));
    check("flush_miss_count", 32'(bus.miss_count), 32'(m_misses));
    @(negedge clock);
    check("flush_done_pulse", 32'(bus.flush_done), 32'd0);
    $display("FLUSH with_req=%0b writebacks=%0d cyc=%0d", with_req, n_ops, cyc);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] got;
    int          cyc;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_be    = '0;
    bus.flush     = 1'b0;

    // Asynchronous reset takes effect before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_cpu_busy", 32'(bus.cpu_busy), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_flush_done", 32'(bus.flush_done), 32'd0);
    check("rst_hit_count", 32'(bus.hit_count), 32'd0);
    check("rst_miss_count", 32'(bus.miss_count), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // Cold load miss, then hit.
    fixed_delay = 3;
    preset(32'h10, 32'h0000_0200);
    cpu_op(32'h10, 1'b0, 32'h0, 4'b0000, got);
    check("cold_load_data", got, 32'h0000_0200);
    check("cold_miss_count", 32'(bus.miss_count), 32'd1);
    cpu_op(32'h10, 1'b0, 32'h0, 4'b0000, got);
    check("warm_hit_count", 32'(bus.hit_count), 32'd1);

    // Store-hit byte merge.
    preset(32'h08, 32'h1122_3344);
    cpu_op(32'h08, 1'b0, 32'h0, 4'b0000, got);
    cpu_op(32'h08, 1'b1, 32'hAABB_CCDD, 4'b0101, got);
    check("store_merge", got, 32'h11BB_33DD);
    cpu_op(32'h08, 1'b0, 32'h0, 4'b0000, got);
    check("load_after_merge", got, 32'h11BB_33DD);

    // Dirty conflict eviction: writeback of 0x04 precedes refill of 0x14.
    cpu_op(32'h04, 1'b1, 32'hCAFE_0001, 4'b1111, got);
    cpu_op(32'h14, 1'b0, 32'h0, 4'b0000, got);
    check("evict_wb_data", mem_rd(32'h04), 32'hCAFE_0001);

    // Clean everything, then dirty indices 1 and 3 only and flush them.
    do_flush(1'b0, 32'h0);
    cpu_op(32'h04, 1'b1, 32'h0102_0304, 4'b1111, got);
    cpu_op(32'h0C, 1'b1, 32'h0A0B_0C0D, 4'b0011, got);
    do_flush(1'b0, 32'h0);
    check("flush_wb_idx1", mem_rd(32'h04), 32'h0102_0304);
    cpu_op(32'h04, 1'b0, 32'h0, 4'b0000, got);
    check("post_flush_reload", got, 32'h0102_0304);
    cpu_op(32'h0C, 1'b0, 32'h0, 4'b0000, got);

    // All-clean flush timing, then flush vs. request priority.
    do_flush(1'b0, 32'h0);
    do_flush(1'b1, 32'h30);

    // Counter saturation.
    repeat (20) cpu_op(32'h04, 1'b0, 32'h0, 4'b0000, got);
    check("hit_saturated", 32'(bus.hit_count), 32'd15);

    // Randomized traffic over a small, conflicting address window.
    fixed_delay = -1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_flush(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)));
      end else begin
        cpu_op(32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), $urandom,
               4'($urandom_range(0, 15)), got);
      end
    end

    // Reset in the middle of a refill.
    fixed_delay = 3;
    begin
      bit          hit;
      logic [31:0] exp_rd;
      int          n_ops;
      model_op(32'h200, 1'b0, 32'h0, 4'b0000, hit, exp_rd, n_ops);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h200;
      bus.cpu_be   = 4'b0000;
      @(negedge clock);
      bus.cpu_req = 1'b0;
      cyc = 0;
      while (!(bus.mem_req && !bus.mem_we) && cyc < 50) begin
        @(negedge clock);
        cyc++;
      end
      check("refill_started", 32'(bus.mem_req && !bus.mem_we), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("midrst_mem_req", 32'(bus.mem_req), 32'd0);
      check("midrst_cpu_busy", 32'(bus.cpu_busy), 32'd0);
      check("midrst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
      check("midrst_miss_count", 32'(bus.miss_count), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      model_reset();
      $display("RESET during refill of 0x00000200");
    end
    cpu_op(32'h200, 1'b0, 32'h0, 4'b0000, got);
    check("post_reset_miss", 32'(bus.miss_count), 32'd1);
    check("post_reset_hit", 32'(bus.hit_count), 32'd0);
    check("post_reset_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv_dcache_wb.md
Name: riscv_dcache_wb

Overview:
- Parametrised direct-mapped data cache for the RISC-V pipeline MEM stage.
- Write-back, write-allocate policy with per-line dirty bits and byte-enable stores.
- Multi-cycle req/ack handshake to backing memory, a line-flush operation, and saturating hit/miss counters.
- Sits between the MEM stage (CPU side) and data memory; one 32-bit word per line.

Parameters:
ADDR_W, 32, byte-address width
LINES, 4, number of cache lines; power of 2, >=2
CNT_W, 16, hit/miss counter width

Ports:
clock  in  1  clock
reset  in  1  reset, asynchronous, active-high
cpu_req  in  1  access request, sampled only while cpu_busy=0
cpu_we  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored
cpu_wdata  in  32  store data
cpu_be  in  4  store byte enables; bit n covers byte n
cpu_rdata  out  32  load data, or the merged word for stores
cpu_ready  out  1  one-cycle response pulse
cpu_busy  out  1  1 whenever FSM is not IDLE
flush  in  1  write back all dirty lines
flush_done  out  1  one-cycle pulse when flush completes
mem_req  out  1  memory request, held until ack
mem_we  out  1  1=writeback, 0=refill
mem_addr  out  ADDR_W  word-aligned address; bits [1:0]=0
mem_wdata  out  32  writeback data
mem_rdata  in  32  refill data, valid with mem_ack
mem_ack  in  1  one-cycle completion; ignored when mem_req=0
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Address split: index = cpu_addr[log2(LINES)+1:2]; tag = remaining upper bits.
- Reset (async, effective immediately): all valid and dirty bits cleared; FSM to IDLE. All outputs 0: cpu_rdata, cpu_ready, cpu_busy, mem_req, mem_we, mem_addr, mem_wdata, flush_done, both counters.
- Reset mid-transaction abandons it. mem_req drops immediately; memory must tolerate the dropped request.
- FSM states: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB.
- IDLE, flush=1: enter FLUSH_SCAN at index 0. Flush has priority over a same-cycle cpu_req; that request is dropped and the CPU must retry.
- IDLE, cpu_req hit: cpu_ready=1 the next cycle (latency 1); hit_count+1.
  - Load hit: cpu_rdata = line data.
  - Store hit: merge enabled bytes into the line and return the merged word on cpu_rdata. dirty=1 only if cpu_be!=0.
- IDLE, cpu_req miss: miss_count+1; latch addr, we, wdata and be.
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise: go to REFILL.
- WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata=victim data. On mem_ack: go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr = latched address aligned. On mem_ack:
  - Install mem_rdata with valid=1, dirty=0.
  - For a store, apply the byte merge on top (dirty=1 if be!=0).
  - Next cycle: cpu_ready pulse with the resulting word; return to IDLE.
- mem_* outputs are registered. mem_req deasserts the cycle after mem_ack. Back-to-back WRITEBACK→REFILL may hold mem_req high continuously; mem_we/mem_addr change on the cycle after the ack.
- FLUSH_SCAN: examines one index per cycle.
  - Dirty line: go to FLUSH_WB (same mem protocol as WRITEBACK). On ack: clear dirty, keep valid, resume scan at next index.
  - After index LINES-1: flush_done pulse for 1 cycle, return to IDLE.
  - An all-clean cache takes exactly LINES cycles.
- Flush writebacks do not change the counters.
- Counters saturate at all-ones.
- cpu_req and flush are ignored while cpu_busy=1.

Test Plan:
- Cold load miss then hit:
  - Stimulus: memory word 0x10 = 0x00000200; ack 3 cycles after req; load 0x10.
  - Required: single mem read at 0x10; cpu_ready with 0x00000200; miss_count=1.
  - Repeat load: ready 1 cycle later, no mem_req, hit_count=1.
- Store-hit merge:
  - Stimulus: line 0x08 = 0x11223344; store 0xAABBCCDD, be=4'b0101.
  - Required: cpu_rdata=0x11BB33DD; no mem traffic.
  - Subsequent load returns 0x11BB33DD.
- Dirty conflict eviction (LINES=4):
  - Stimulus: line 0x04 dirty with 0xCAFE0001; load 0x14.
  - Required: writeback to 0x04 with 0xCAFE0001 first, then refill read of 0x14; cpu_ready only after refill ack.
- Flush:
  - Stimulus: dirty lines at indices 1 and 3, clean lines elsewhere; assert flush.
  - Required: exactly two writebacks, index 1 then index 3; flush_done pulse once. Re-load of both addresses hits with no mem traffic.
- Reset mid-refill:
  - Stimulus: assert reset while mem_req=1.
  - Required: mem_req=0 and cpu_busy=0 without waiting for a clock edge. Load of the same address afterwards misses (miss_count=1 post-reset).
- Priority and saturation:
  - Stimulus: flush and cpu_req in the same IDLE cycle.
  - Required: flush runs, no cpu_ready for that request.
  - With CNT_W=4: 20 hits leave hit_count=15.
